// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 multiplier datapath constants and types
package fp_pkg;
    localparam int WIDTH      = 32;
    localparam int EXP_WIDTH  = 8;
    localparam int SIG_WIDTH  = 23;
    localparam int BIAS       = 127;
    localparam int PROD_WIDTH = 2 * (SIG_WIDTH + 1);
    localparam int EXPI_WIDTH = EXP_WIDTH + 2;
    localparam int EXP_MAX    = 2 * BIAS + 1;

    localparam logic [1:0] RND_RNE = 2'b00;
    localparam logic [1:0] RND_RTZ = 2'b01;
    localparam logic [1:0] RND_RUP = 2'b10;
    localparam logic [1:0] RND_RDN = 2'b11;

    localparam logic [WIDTH-1:0] QNAN       = 32'h7FC00000;
    localparam logic [WIDTH-2:0] MAX_FINITE = 31'h7F7FFFFF;

    typedef struct packed {
        logic                  sign;
        logic [EXPI_WIDTH-1:0] e;
        logic [SIG_WIDTH-1:0]  frac;
        logic                  g;
        logic                  s;
        logic [1:0]            rnd;
        logic                  nan;
        logic                  inf;
        logic                  zero;
    } norm_t;
endpackage

// File: rtl/fp_round_inc.sv
// rtl/fp_round_inc.sv - rounding increment decision for all four rounding modes
module fp_round_inc
    import fp_pkg::*;
(
    input  logic [1:0] rnd,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rnd)
            RND_RNE: inc = g & (s | lsb);
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = !sign & (g | s);
            RND_RDN: inc = sign & (g | s);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_mult_norm_round.sv
// rtl/fp_mult_norm_round.sv - FP32 multiplier normalize/round stage, 2-deep pipeline
module fp_mult_norm_round
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXPI_WIDTH-1:0] in_exp,
    input  logic [PROD_WIDTH-1:0] in_sig,
    input  logic                  in_nan,
    input  logic                  in_inf,
    input  logic                  in_zero,
    input  logic [1:0]            rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);

    localparam logic [WIDTH-2:0]      INF_MAG = {{EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    localparam logic [EXPI_WIDTH-1:0] E_OVF   = EXPI_WIDTH'(EXP_MAX);

    logic                  en;
    logic                  s1_valid;
    norm_t                 s1, s1_nxt;
    logic [PROD_WIDTH-2:0] nsig;

    logic                  inc, carry;
    logic [SIG_WIDTH-1:0]  frac_r;
    logic [EXPI_WIDTH-1:0] e_r;
    logic [WIDTH-1:0]      res_nxt;
    logic                  ovf_nxt, unf_nxt, inx_nxt;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // A product in [2,4) is shifted right one place; aligning it here keeps a single slice below.
    always_comb begin
        nsig         = in_sig[PROD_WIDTH-1] ? in_sig[PROD_WIDTH-2:0]
                                            : {in_sig[PROD_WIDTH-3:0], 1'b0};
        s1_nxt.sign  = in_sign;
        s1_nxt.e     = in_exp + {{(EXPI_WIDTH-1){1'b0}}, in_sig[PROD_WIDTH-1]};
        s1_nxt.frac  = nsig[PROD_WIDTH-2 -: SIG_WIDTH];
        s1_nxt.g     = nsig[PROD_WIDTH-2-SIG_WIDTH];
        s1_nxt.s     = |nsig[PROD_WIDTH-3-SIG_WIDTH:0];
        s1_nxt.rnd   = rnd;
        s1_nxt.nan   = in_nan;
        s1_nxt.inf   = in_inf;
        s1_nxt.zero  = in_zero;
    end

    fp_round_inc u_round_inc (
        .rnd  (s1.rnd),
        .sign (s1.sign),
        .lsb  (s1.frac[0]),
        .g    (s1.g),
        .s    (s1.s),
        .inc  (inc)
    );

    always_comb begin
        {carry, frac_r} = {1'b0, s1.frac} + {{SIG_WIDTH{1'b0}}, inc};
        e_r     = s1.e + {{(EXPI_WIDTH-1){1'b0}}, carry};
        res_nxt = {s1.sign, e_r[EXP_WIDTH-1:0], frac_r};
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        inx_nxt = s1.g | s1.s;
        if (s1.nan) begin
            res_nxt = QNAN;
            inx_nxt = 1'b0;
        end else if (s1.inf) begin
            res_nxt = {s1.sign, INF_MAG};
            inx_nxt = 1'b0;
        end else if (s1.zero) begin
            res_nxt = {s1.sign, {(WIDTH-1){1'b0}}};
            inx_nxt = 1'b0;
        end else if (s1.e[EXPI_WIDTH-1] || s1.e == '0) begin
            // Underflow judged on the pre-round exponent: no rounding up into the normal range.
            res_nxt = {s1.sign, {(WIDTH-1){1'b0}}};
            unf_nxt = 1'b1;
            inx_nxt = 1'b1;
        end else if (!e_r[EXPI_WIDTH-1] && e_r >= E_OVF) begin
            ovf_nxt = 1'b1;
            inx_nxt = 1'b1;
            case (s1.rnd)
                RND_RNE: res_nxt = {s1.sign, INF_MAG};
                RND_RTZ: res_nxt = {s1.sign, MAX_FINITE};
                RND_RUP: res_nxt = {s1.sign, s1.sign ? MAX_FINITE : INF_MAG};
                default: res_nxt = {s1.sign, s1.sign ? INF_MAG : MAX_FINITE};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1        <= s1_nxt;
            out_valid <= s1_valid;
            result    <= res_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
            inexact   <= inx_nxt;
        end
    end

endmodule
